// File: rtl/unibus_dma_master.sv
// Unibus NPR (DMA) bus master: arbitrates for the bus, runs one DATI/DATO cycle, releases.
// Optional UNIBUS_DMA_BYTE_EN adds an xbyte input for DATOB byte writes.
module unibus_dma_master #(
    parameter int DESKEW  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        init_in_h,
    input  logic        xreq,
    input  logic        xwrite,
    input  logic [17:0] xaddr,
    input  logic [15:0] xwdata,
`ifdef UNIBUS_DMA_BYTE_EN
    input  logic        xbyte,
`endif
    output logic [15:0] xrdata,
    output logic        xdone,
    output logic        xerr,
    output logic        npr_out_h,
    input  logic        npg_in_h,
    output logic        sack_out_h,
    input  logic        bbsy_in_h,
    output logic        bbsy_out_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h,
    input  logic [15:0] d_in_h,
    output logic        msyn_out_h,
    input  logic        ssyn_in_h
);
    typedef enum logic [2:0] {IDLE, REQ, WAITBUS, SETUP, WAITSSYN, LATCH, ENDCYC, ABORT} state_t;

    state_t      state;
    logic [9:0]  cnt;
    logic [3:0]  sync_q1, sync_q2;
    logic        init_s, bbsy_s, npg_s, ssyn_s;
    logic        cyc_write;
    logic [17:0] cyc_a, req_a;
    logic [1:0]  cyc_c, req_c;
    logic [15:0] cyc_d, req_d;
    logic        timeout_hit, abort_now;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {init_in_h, bbsy_in_h, npg_in_h, ssyn_in_h};
            sync_q2 <= sync_q1;
        end
    end
    assign {init_s, bbsy_s, npg_s, ssyn_s} = sync_q2;

    // Bus address/code/data for the cycle are resolved when the request is taken.
    always_comb begin
        req_a = {xaddr[17:1], 1'b0};
        req_c = xwrite ? 2'b10 : 2'b00;
        req_d = xwrite ? xwdata : 16'h0000;
`ifdef UNIBUS_DMA_BYTE_EN
        if (xwrite && xbyte) begin
            req_a = xaddr;
            req_c = 2'b11;
            req_d = xaddr[0] ? {xwdata[7:0], 8'h00} : {8'h00, xwdata[7:0]};
        end
`endif
    end

    // The shared counter only times out where a wait condition is still unmet.
    always_comb begin
        timeout_hit = (cnt == 10'(TIMEOUT)) &&
                      ((state == REQ      && !npg_s)  ||
                       (state == WAITSSYN && !ssyn_s) ||
                       (state == ENDCYC   &&  ssyn_s));
        abort_now   = (state != IDLE) && (state != ABORT) && (init_s || timeout_hit);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            cyc_write  <= 1'b0;
            cyc_a      <= '0;
            cyc_c      <= '0;
            cyc_d      <= '0;
            xrdata     <= '0;
            xdone      <= 1'b0;
            xerr       <= 1'b0;
            npr_out_h  <= 1'b0;
            sack_out_h <= 1'b0;
            bbsy_out_h <= 1'b0;
            a_out_h    <= '0;
            c_out_h    <= '0;
            d_out_h    <= '0;
            msyn_out_h <= 1'b0;
        end else begin
            xdone <= 1'b0;
            xerr  <= 1'b0;
            if (abort_now) begin
                npr_out_h  <= 1'b0;
                sack_out_h <= 1'b0;
                bbsy_out_h <= 1'b0;
                msyn_out_h <= 1'b0;
                a_out_h    <= '0;
                c_out_h    <= '0;
                d_out_h    <= '0;
                xdone      <= 1'b1;
                xerr       <= 1'b1;
                state      <= ABORT;
            end else begin
                case (state)
                    IDLE: if (xreq && !init_s) begin
                        cyc_write <= xwrite;
                        cyc_a     <= req_a;
                        cyc_c     <= req_c;
                        cyc_d     <= req_d;
                        npr_out_h <= 1'b1;
                        cnt       <= '0;
                        state     <= REQ;
                    end
                    REQ: if (npg_s) begin
                        sack_out_h <= 1'b1;
                        npr_out_h  <= 1'b0;
                        state      <= WAITBUS;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                    WAITBUS: if (!npg_s && !bbsy_s && !ssyn_s) begin
                        bbsy_out_h <= 1'b1;
                        a_out_h    <= cyc_a;
                        c_out_h    <= cyc_c;
                        d_out_h    <= cyc_d;
                        cnt        <= '0;
                        state      <= SETUP;
                    end
                    SETUP: if (cnt == 10'(DESKEW - 1)) begin
                        msyn_out_h <= 1'b1;
                        cnt        <= '0;
                        state      <= WAITSSYN;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                    WAITSSYN: if (ssyn_s) begin
                        cnt   <= '0;
                        state <= LATCH;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                    LATCH: if (cnt == 10'(DESKEW - 1)) begin
                        if (!cyc_write) xrdata <= d_in_h;
                        msyn_out_h <= 1'b0;
                        cnt        <= '0;
                        state      <= ENDCYC;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                    ENDCYC: if (!ssyn_s) begin
                        bbsy_out_h <= 1'b0;
                        sack_out_h <= 1'b0;
                        a_out_h    <= '0;
                        c_out_h    <= '0;
                        d_out_h    <= '0;
                        xdone      <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                    ABORT:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_unibus_dma_master.sv
// Directed bench for unibus_dma_master: acts as arbiter and slave on the bus side.
module tb_unibus_dma_master;
    localparam int DESKEW  = 8;
    localparam int TIMEOUT = 1023;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        init_in_h = 1'b0, xreq = 1'b0, xwrite = 1'b0, xbyte = 1'b0;
    logic [17:0] xaddr = '0;
    logic [15:0] xwdata = '0, d_in_h = '0;
    logic        npg_in_h = 1'b0, bbsy_in_h = 1'b0, ssyn_in_h = 1'b0;
    logic [15:0] xrdata, d_out_h;
    logic        xdone, xerr, npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    int          checks = 0, failures = 0, bbsy_cycles = 0;

    unibus_dma_master #(.DESKEW(DESKEW), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .init_in_h(init_in_h), .xreq(xreq), .xwrite(xwrite),
        .xaddr(xaddr), .xwdata(xwdata),
`ifdef UNIBUS_DMA_BYTE_EN
        .xbyte(xbyte),
`endif
        .xrdata(xrdata), .xdone(xdone), .xerr(xerr), .npr_out_h(npr_out_h), .npg_in_h(npg_in_h),
        .sack_out_h(sack_out_h), .bbsy_in_h(bbsy_in_h), .bbsy_out_h(bbsy_out_h), .a_out_h(a_out_h),
        .c_out_h(c_out_h), .d_out_h(d_out_h), .d_in_h(d_in_h), .msyn_out_h(msyn_out_h),
        .ssyn_in_h(ssyn_in_h));

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) if (bbsy_out_h) bbsy_cycles <= bbsy_cycles + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return npr_out_h;
            1: return sack_out_h;
            2: return bbsy_out_h;
            3: return msyn_out_h;
            default: return xdone;
        endcase
    endfunction

    // Bounded wait, sampled on negedges; n = negedges elapsed before the level is seen.
    task automatic wait_for(input string tag, input int sel, input logic val, input int limit,
                            output int n);
        bit ok = 0;
        n = 0;
        for (int i = 0; i <= limit; i++) begin
            if (sig(sel) === val) begin
                n = i;
                ok = 1;
                break;
            end
            @(negedge CLOCK);
        end
        check({tag, "_wait"}, 32'(ok), 32'd1);
    endtask

    task automatic start(input logic wr, input logic byt, input logic [17:0] addr,
                         input logic [15:0] wd);
        xwrite = wr; xbyte = byt; xaddr = addr; xwdata = wd; xreq = 1'b1;
        @(negedge CLOCK);
        xreq = 1'b0;
    endtask

    task automatic grant(input string tag, input int gdly);
        int n;
        wait_for({tag, "_npr"}, 0, 1'b1, 4, n);
        repeat (gdly) @(negedge CLOCK);
        npg_in_h = 1'b1;
        wait_for({tag, "_sack"}, 1, 1'b1, 8, n);
        check({tag, "_npr_drop"}, 32'(npr_out_h), 32'd0);
        npg_in_h = 1'b0;
    endtask

    task automatic do_xfer(input string tag, input logic wr, input logic byt,
                           input logic [17:0] addr, input logic [15:0] wd, input logic [15:0] rd,
                           input int gdly, input logic [17:0] ea, input logic [1:0] ec,
                           input logic [15:0] ed, input logic [15:0] er);
        int n;
        start(wr, byt, addr, wd);
        grant(tag, gdly);
        wait_for({tag, "_bbsy"}, 2, 1'b1, 12, n);
        check({tag, "_a"}, 32'(a_out_h), 32'(ea));
        check({tag, "_c"}, 32'(c_out_h), 32'(ec));
        check({tag, "_d"}, 32'(d_out_h), 32'(ed));
        wait_for({tag, "_msyn"}, 3, 1'b1, 3 * DESKEW, n);
        check({tag, "_deskew"}, 32'(n), 32'(DESKEW));
        check({tag, "_d_msyn"}, 32'(d_out_h), 32'(ed));
        d_in_h = rd; ssyn_in_h = 1'b1;
        wait_for({tag, "_msyn_drop"}, 3, 1'b0, 3 * DESKEW, n);
        ssyn_in_h = 1'b0; d_in_h = '0;
        wait_for({tag, "_done"}, 4, 1'b1, 12, n);
        check({tag, "_xerr"}, 32'(xerr), 32'd0);
        check({tag, "_xrdata"}, 32'(xrdata), 32'(er));
        check({tag, "_rel"}, {bbsy_out_h, sack_out_h, msyn_out_h, a_out_h, c_out_h},
              32'd0);
        check({tag, "_rel_d"}, 32'(d_out_h), 32'd0);
        @(negedge CLOCK);
        check({tag, "_pulse"}, 32'(xdone), 32'd0);
    endtask

    initial begin
        int n, b0;
        repeat (3) @(negedge CLOCK);
        check("rst_ctl", {xdone, xerr, npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h}, 32'd0);
        check("rst_bus", {a_out_h, c_out_h}, 32'd0);
        check("rst_data", {d_out_h, xrdata}, 32'd0);
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK);
        check("idle_npr", 32'(npr_out_h), 32'd0);

        do_xfer("dati", 1'b0, 1'b0, 18'o001000, 16'h0, 16'o123456, 5,
                18'o001000, 2'b00, 16'h0, 16'o123456);
        do_xfer("dato", 1'b1, 1'b0, 18'o774400, 16'o000204, 16'o177777, 0,
                18'o774400, 2'b10, 16'o000204, 16'o123456);
        do_xfer("odd_word", 1'b1, 1'b1, 18'o001001, 16'o000252, 16'h0, 0,
`ifdef UNIBUS_DMA_BYTE_EN
                18'o001001, 2'b11, 16'o125000, 16'o123456);
`else
                18'o001000, 2'b10, 16'o000252, 16'o123456);
`endif

        // no grant ever arrives
        b0 = bbsy_cycles;
        start(1'b0, 1'b0, 18'o002000, 16'h0);
        wait_for("nogrant_npr", 0, 1'b1, 4, n);
        wait_for("nogrant_drop", 0, 1'b0, TIMEOUT + 20, n);
        check("nogrant_time", 32'(n), 32'(TIMEOUT + 1));
        check("nogrant_done", {xdone, xerr}, 32'b11);
        check("nogrant_bbsy", 32'(bbsy_cycles - b0), 32'd0);
        repeat (3) @(negedge CLOCK);

        // grant but no slave responds
        start(1'b0, 1'b0, 18'o003000, 16'h0);
        grant("noslave", 0);
        wait_for("noslave_msyn", 3, 1'b1, 3 * DESKEW + 8, n);
        wait_for("noslave_drop", 3, 1'b0, TIMEOUT + 20, n);
        check("noslave_time", 32'(n >= TIMEOUT && n <= TIMEOUT + 1), 32'd1);
        check("noslave_done", {xdone, xerr}, 32'b11);
        check("noslave_bus", {bbsy_out_h, sack_out_h, a_out_h, c_out_h}, 32'd0);
        repeat (3) @(negedge CLOCK);

        // INIT while waiting for SSYN
        start(1'b1, 1'b0, 18'o004000, 16'o000777);
        grant("init", 0);
        wait_for("init_msyn", 3, 1'b1, 3 * DESKEW + 8, n);
        init_in_h = 1'b1;
        wait_for("init_bbsy", 2, 1'b0, 4, n);
        check("init_ctl", {msyn_out_h, sack_out_h, bbsy_out_h}, 32'd0);
        check("init_done", {xdone, xerr}, 32'b11);
        check("init_bus", {a_out_h, c_out_h, d_out_h}, 32'd0);
        init_in_h = 1'b0;
        repeat (4) @(negedge CLOCK);
        do_xfer("after_init", 1'b0, 1'b0, 18'o005002, 16'h0, 16'o052525, 2,
                18'o005002, 2'b00, 16'h0, 16'o052525);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/unibus_dma_master.md
Name: unibus_dma_master

Overview:
- Unibus NPR (DMA) bus master: requests the bus, becomes master, performs one DATI/DATO cycle, then releases the bus.
- This is the initiator end of the MSYN/SSYN handshake that the register slaves answer.
- Used by disk controller models (RL/RK) to move sector data between ARM buffers and PDP memory.
- The ARM side issues one word per request and gets a completion pulse plus status.

Parameters:
- DESKEW, 8: clock cycles that address/control/data are held stable before MSYN is asserted, and again after SSYN is seen before read data is latched.
- TIMEOUT, 1023: clock cycles allowed for NPG to arrive, and again for SSYN to arrive, before the cycle is aborted.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  reset; asynchronous, active-low.
- init_in_h  in  1  Unibus INIT; aborts any transfer in progress.
- xreq  in  1  start pulse; sampled only in IDLE.
- xwrite  in  1  1=DATO, 0=DATI.
- xaddr  in  18  Unibus byte address; bit 0 is ignored for word cycles.
- xwdata  in  16  write data.
- xrdata  out  16  read data.
- xdone  out  1  one-cycle completion pulse.
- xerr  out  1  valid with xdone: 1 = timeout or INIT abort.
- npr_out_h  out  1  non-processor request.
- npg_in_h  in  1  non-processor grant.
- sack_out_h  out  1  selection acknowledge.
- bbsy_in_h  in  1  bus busy, from another master.
- bbsy_out_h  out  1  this block is bus master.
- a_out_h  out  18  address to bus.
- c_out_h  out  2  cycle code: 00 DATI, 10 DATO, 11 DATOB.
- d_out_h  out  16  write data to bus.
- d_in_h  in  16  read data from bus.
- msyn_out_h  out  1  master sync.
- ssyn_in_h  in  1  slave sync.

Behaviour:
- Reset (RESET low): all outputs 0, state IDLE.
- Bus outputs a/c/d are 0 whenever bbsy_out_h=0.
- State machine (one 10-bit counter is shared for DESKEW and TIMEOUT):
  - IDLE: on xreq, latch xwrite/xaddr/xwdata, set npr_out_h=1, clear counter, go REQ.
  - REQ: on npg_in_h=1, set sack_out_h=1, set npr_out_h=0, go WAITBUS. If the counter reaches TIMEOUT first, go ABORT.
  - WAITBUS: wait for npg_in_h=0, bbsy_in_h=0 and ssyn_in_h=0. Then set bbsy_out_h=1, drive a_out_h/c_out_h (plus d_out_h if write), clear counter, go SETUP.
  - SETUP: after DESKEW cycles, set msyn_out_h=1, clear counter, go WAITSSYN.
  - WAITSSYN: on ssyn_in_h=1, clear counter and go LATCH. If TIMEOUT is reached first, go ABORT.
  - LATCH: after DESKEW cycles, capture xrdata<=d_in_h (reads only; writes leave xrdata unchanged), set msyn_out_h=0, go ENDCYC.
  - ENDCYC: wait for ssyn_in_h=0 (TIMEOUT applies -> ABORT). Then set bbsy_out_h=0, sack_out_h=0, zero a/c/d, pulse xdone with xerr=0, go IDLE.
  - ABORT: clear all bus outputs in the same cycle, pulse xdone with xerr=1, go IDLE.
- ssyn_in_h, npg_in_h, bbsy_in_h and init_in_h pass through 2-flop synchronizers. All waits and latencies above are measured from the synchronized versions.
- init_in_h=1 in any non-IDLE state -> ABORT on the next cycle. In IDLE, xreq is ignored while init_in_h=1.
- xreq outside IDLE is ignored; no queueing.
- Minimum write latency, xreq to xdone, with immediate grant and SSYN: 2*DESKEW + about 8 cycles.

Optional Feature:
- UNIBUS_DMA_BYTE_EN, when defined:
  - Adds input xbyte (1 bit).
  - A write with xbyte=1 drives c_out_h=11 (DATOB), passes a_out_h[0]=xaddr[0], and drives the byte on d_out_h[7:0] when xaddr[0]=0 and on d_out_h[15:8] when xaddr[0]=1. xwdata[7:0] is the byte source in both cases.
  - A read with xbyte=1 is a normal DATI.
- When not defined: no xbyte port, a_out_h[0] is forced to 0, and writes always use c_out_h=10.

Test Plan:
- DATI: xreq with xwrite=0, xaddr=18'o001000; slave grants NPG after 5 cycles and returns 16'o123456 with SSYN -> NPR/SACK/BBSY sequence correct, MSYN rises DESKEW cycles after a_out_h is valid, xrdata=16'o123456, xdone=1 with xerr=0.
- DATO: xwrite=1, xaddr=18'o774400, xwdata=16'o000204 -> c_out_h=10 and d_out_h=16'o000204 while MSYN=1, everything released after SSYN drops, xerr=0.
- No grant: npg_in_h held 0 -> npr_out_h drops after TIMEOUT+1 cycles, xdone with xerr=1, no BBSY ever asserted.
- No slave: grant given, ssyn_in_h held 0 -> msyn_out_h high for TIMEOUT cycles, then all bus outputs 0 and xerr=1.
- INIT mid-cycle: init_in_h=1 while in WAITSSYN -> msyn/bbsy/sack all 0 within 4 cycles, xdone with xerr=1; a following xreq completes normally.
- Byte write (UNIBUS_DMA_BYTE_EN): xbyte=1, xaddr=18'o001001, xwdata=16'o000252 -> c_out_h=11, a_out_h=18'o001001, d_out_h[15:8]=8'o252.
